// File: rtl/ne_fp_add_arb.sv
// Round-robin arbiter sharing one pipelined FP/INT adder among NREQ requesters, one credit each.
// Optional macro NE_FP_ADD_ARB_STATS_EN adds per-requester issue/stall counters.
module ne_fp_add_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned BWA  = 41,
    parameter int unsigned BWZ  = 42,
    parameter int unsigned LAT  = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*BWA-1:0]  req_a_i,
    input  logic [NREQ*BWA-1:0]  req_b_i,
    input  logic [NREQ*3-1:0]    req_mode_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    input  logic [NREQ-1:0]      rsp_ready_i,
    output logic [NREQ*BWZ-1:0]  rsp_z_o,
    output logic [NREQ*3-1:0]    rsp_mode_o,
    output logic [BWA-1:0]       add_a_o,
    output logic [BWA-1:0]       add_b_o,
    output logic [2:0]           add_mode_o,
    input  logic [BWZ-1:0]       add_z_i
`ifdef NE_FP_ADD_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0]   stat_issue_o,
    output logic [NREQ*16-1:0]   stat_stall_o
`endif
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] inflight_q, inflight_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0] eligible, grant, wr_sel;
    logic            gnt_any;
    logic [IdxW-1:0] gnt_idx;

    logic [BWZ-1:0]  buf_z_q    [NREQ];
    logic [2:0]      buf_mode_q [NREQ];

    logic [LAT-1:0]  tag_v_q;
    logic [IdxW-1:0] tag_idx_q  [LAT];
    logic [2:0]      tag_mode_q [LAT];

    logic            wr_en;
    logic [IdxW-1:0] wr_idx;

    // A requester may only hold one op in the pipe or buffer at a time.
    always_comb begin
        eligible = req_valid_i & ~inflight_q & (~rsp_valid_q | rsp_ready_i);
    end

    always_comb begin
        int unsigned cand;
        logic [IdxW-1:0] cand_idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IdxW'(cand);
            if (!gnt_any && eligible[cand_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    always_comb begin
        grant = '0;
        if (gnt_any && !rst_i) begin
            grant[gnt_idx] = 1'b1;
        end
        req_ready_o = grant;
    end

    always_comb begin
        add_a_o    = '0;
        add_b_o    = '0;
        add_mode_o = 3'b000;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                add_a_o    = req_a_i[i*BWA +: BWA];
                add_b_o    = req_b_i[i*BWA +: BWA];
                add_mode_o = req_mode_i[i*3 +: 3];
            end
        end
    end

    // Last tag stage lines up with add_z_i for the op issued LAT cycles ago.
    always_comb begin
        wr_en  = tag_v_q[LAT-1];
        wr_idx = tag_idx_q[LAT-1];
        for (int i = 0; i < NREQ; i++) begin
            wr_sel[i] = wr_en && (wr_idx == IdxW'(i));
        end
        rsp_valid_d = (rsp_valid_q & ~rsp_ready_i) | wr_sel;
        inflight_d  = (inflight_q & ~wr_sel) | grant;
        rr_ptr_d    = (|grant) ? gnt_idx : rr_ptr_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q    <= IdxW'(NREQ - 1);
            inflight_q  <= '0;
            rsp_valid_q <= '0;
            tag_v_q     <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_idx_q[k]  <= '0;
                tag_mode_q[k] <= 3'b000;
            end
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            inflight_q    <= inflight_d;
            rsp_valid_q   <= rsp_valid_d;
            tag_v_q[0]    <= |grant;
            tag_idx_q[0]  <= gnt_idx;
            tag_mode_q[0] <= add_mode_o;
            for (int k = 1; k < LAT; k++) begin
                tag_v_q[k]    <= tag_v_q[k-1];
                tag_idx_q[k]  <= tag_idx_q[k-1];
                tag_mode_q[k] <= tag_mode_q[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREQ; i++) begin
                buf_z_q[i]    <= '0;
                buf_mode_q[i] <= 3'b000;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (wr_sel[i]) begin
                    buf_z_q[i]    <= add_z_i;
                    buf_mode_q[i] <= tag_mode_q[LAT-1];
                end
            end
        end
    end

    always_comb begin
        rsp_valid_o = rsp_valid_q;
        for (int i = 0; i < NREQ; i++) begin
            rsp_z_o[i*BWZ +: BWZ] = buf_z_q[i];
            rsp_mode_o[i*3 +: 3]  = buf_mode_q[i];
        end
    end

`ifdef NE_FP_ADD_ARB_STATS_EN
    logic [15:0] stat_issue_q [NREQ];
    logic [15:0] stat_stall_q [NREQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREQ; i++) begin
                stat_issue_q[i] <= '0;
                stat_stall_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant[i] && (stat_issue_q[i] != 16'hFFFF)) begin
                    stat_issue_q[i] <= stat_issue_q[i] + 16'd1;
                end
                if (req_valid_i[i] && !grant[i] && (stat_stall_q[i] != 16'hFFFF)) begin
                    stat_stall_q[i] <= stat_stall_q[i] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            stat_issue_o[i*16 +: 16] = stat_issue_q[i];
            stat_stall_o[i*16 +: 16] = stat_stall_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_ne_fp_add_arb.sv
// Bench for ne_fp_add_arb: LAT=1 instance checked by a per-requester scoreboard, LAT=3 instance
// checked inline; both share the request stimulus and are fed by a stand-in pipelined adder.
module tb_ne_fp_add_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned BWA  = 41;
    localparam int unsigned BWZ  = 42;
    localparam logic [BWA-1:0] ONE = {3'b000, 1'b0, 10'h1FF, 27'h4000000};

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid, rsp_ready;
    logic [NREQ*BWA-1:0] req_a, req_b;
    logic [NREQ*3-1:0]   req_mode;

    logic [NREQ-1:0]     rdy1, rspv1, rdy3, rspv3;
    logic [NREQ*BWZ-1:0] rspz1, rspz3;
    logic [NREQ*3-1:0]   rspm1, rspm3;
    logic [BWA-1:0]      adda1, addb1, adda3, addb3;
    logic [2:0]          addm1, addm3;
    logic [BWZ-1:0]      addz1, addz3;
    logic [BWZ-1:0]      p1;
    logic [BWZ-1:0]      p3 [3];
`ifdef NE_FP_ADD_ARB_STATS_EN
    logic [NREQ*16-1:0]  si1, ss1, si3, ss3;
`endif

    logic [BWZ+2:0] exp_q [NREQ][$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [BWZ-1:0] fake_add(input logic [BWA-1:0] a, input logic [BWA-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Stand-in adders with 1 and 3 cycles of latency.
    always @(posedge clk) begin
        p1    <= fake_add(adda1, addb1);
        p3[0] <= fake_add(adda3, addb3);
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign addz1 = p1;
    assign addz3 = p3[2];

    ne_fp_add_arb #(.NREQ(NREQ), .BWA(BWA), .BWZ(BWZ), .LAT(1)) u1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy1),
        .req_a_i(req_a), .req_b_i(req_b), .req_mode_i(req_mode), .rsp_valid_o(rspv1),
        .rsp_ready_i(rsp_ready), .rsp_z_o(rspz1), .rsp_mode_o(rspm1), .add_a_o(adda1),
        .add_b_o(addb1), .add_mode_o(addm1), .add_z_i(addz1)
`ifdef NE_FP_ADD_ARB_STATS_EN
        , .stat_issue_o(si1), .stat_stall_o(ss1)
`endif
    );

    ne_fp_add_arb #(.NREQ(NREQ), .BWA(BWA), .BWZ(BWZ), .LAT(3)) u3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(rdy3),
        .req_a_i(req_a), .req_b_i(req_b), .req_mode_i(req_mode), .rsp_valid_o(rspv3),
        .rsp_ready_i(rsp_ready), .rsp_z_o(rspz3), .rsp_mode_o(rspm3), .add_a_o(adda3),
        .add_b_o(addb3), .add_mode_o(addm3), .add_z_i(addz3)
`ifdef NE_FP_ADD_ARB_STATS_EN
        , .stat_issue_o(si3), .stat_stall_o(ss3)
`endif
    );

    // Scoreboard: every consumed response of the LAT=1 instance is popped and compared.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (rspv1[i] && rsp_ready[i]) begin
                    n_checks++;
                    if (exp_q[i].size() == 0) begin
                        $display("FAIL sb_unexpected req%0d: got z=%h mode=%b want no response",
                                 i, rspz1[i*BWZ +: BWZ], rspm1[i*3 +: 3]);
                    end else begin
                        logic [BWZ+2:0] e;
                        e = exp_q[i].pop_front();
                        if ({rspz1[i*BWZ +: BWZ], rspm1[i*3 +: 3]} !== e) begin
                            $display("FAIL sb_rsp req%0d: got %h want %h", i,
                                     {rspz1[i*BWZ +: BWZ], rspm1[i*3 +: 3]}, e);
                        end else begin
                            n_pass++;
                        end
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [BWA-1:0] a, input logic [BWA-1:0] b,
                           input logic [2:0] m);
        req_a[i*BWA +: BWA] = a;
        req_b[i*BWA +: BWA] = b;
        req_mode[i*3 +: 3]  = m;
    endtask

    task automatic push(input int i);
        exp_q[i].push_back({fake_add(req_a[i*BWA +: BWA], req_b[i*BWA +: BWA]),
                            req_mode[i*3 +: 3]});
    endtask

    task automatic clear_sb;
        for (int i = 0; i < NREQ; i++) exp_q[i].delete();
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        tick;
        tick;
        rst = 1'b0;
        clear_sb;
    endtask

    task automatic drain;
        req_valid = '0;
        repeat (6) tick;
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        req_valid = '1;
        req_mode  = {4{3'b100}};
        tick;
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", rdy1);
        else n_pass++;
        n_checks++;
        if (addm1 !== 3'b000) $display("FAIL reset_add_mode: got %b want 000", addm1);
        else n_pass++;
        n_checks++;
        if (rspv1 !== 4'b0000 || rspv3 !== 4'b0000)
            $display("FAIL reset_rsp_valid: got %b/%b want 0000/0000", rspv1, rspv3);
        else n_pass++;
        n_checks++;
        if (rdy3 !== 4'b0000 || addm3 !== 3'b000)
            $display("FAIL reset_lat3: got ready %b mode %b want 0000 000", rdy3, addm3);
        else n_pass++;
        do_reset;
    endtask

    task automatic test_single;
        do_reset;
        set_req(0, ONE, ONE, 3'b100);
        req_valid = 4'b0001;
        push(0);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0001) $display("FAIL single_ready: got %b want 0001", rdy1);
        else n_pass++;
        n_checks++;
        if (addm1 !== 3'b100 || adda1 !== ONE || addb1 !== ONE)
            $display("FAIL single_add_port: got mode %b a %h want 100 %h", addm1, adda1, ONE);
        else n_pass++;
        tick;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (rspv1[0] !== 1'b0) $display("FAIL single_early_rsp: got %b want 0", rspv1[0]);
        else n_pass++;
        n_checks++;
        if (addm1 !== 3'b000 || adda1 !== '0)
            $display("FAIL single_idle_add: got mode %b a %h want 000 0", addm1, adda1);
        else n_pass++;
        tick;
        @(negedge clk);
        n_checks++;
        if (rspv1[0] !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", rspv1[0]);
        else n_pass++;
        drain;
    endtask

    task automatic test_contention;
        int ord [5];
        ord = '{0, 1, 2, 3, 0};
        do_reset;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, BWA'(41'h100 + i), BWA'(41'h7000 + (i << 4)), (i == 1) ? 3'b010 : 3'b100);
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push(ord[k]);
            @(negedge clk);
            n_checks++;
            if (rdy1 !== 4'(1 << ord[k]))
                $display("FAIL contention_grant T%0d: got %b want %b", k, rdy1, 4'(1 << ord[k]));
            else n_pass++;
            tick;
        end
        drain;
    endtask

    task automatic test_backpressure;
        do_reset;
        rsp_ready = 4'b1101;
        set_req(1, 41'h1234, 41'h55, 3'b010);
        req_valid = 4'b0010;
        push(1);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0010) $display("FAIL bp_first_grant: got %b want 0010", rdy1);
        else n_pass++;
        tick;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rdy1 !== 4'b0000) $display("FAIL bp_blocked T%0d: got %b want 0000", k, rdy1);
            else n_pass++;
            if (k >= 2) begin
                n_checks++;
                if (rspv1[1] !== 1'b1) $display("FAIL bp_held T%0d: got %b want 1", k, rspv1[1]);
                else n_pass++;
            end
            tick;
        end
        rsp_ready = 4'b1111;
        push(1);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0010) $display("FAIL bp_grant_on_pop: got %b want 0010", rdy1);
        else n_pass++;
        tick;
        drain;
    endtask

    task automatic test_int;
        do_reset;
        set_req(2, 41'h3F, 41'h41, 3'b001);
        req_valid = 4'b0100;
        push(2);
        @(negedge clk);
        n_checks++;
        if (rdy3 !== 4'b0100 || addm3 !== 3'b001)
            $display("FAIL int_issue: got ready %b mode %b want 0100 001", rdy3, addm3);
        else n_pass++;
        tick;
        req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rspv3[2] !== 1'b0) $display("FAIL int_early T%0d: got %b want 0", k, rspv3[2]);
            else n_pass++;
            tick;
        end
        @(negedge clk);
        n_checks++;
        if (rspv3[2] !== 1'b1 || rspm3[8:6] !== 3'b001)
            $display("FAIL int_rsp: got valid %b mode %b want 1 001", rspv3[2], rspm3[8:6]);
        else n_pass++;
        n_checks++;
        if (rspz3[2*BWZ +: BWZ] !== fake_add(41'h3F, 41'h41))
            $display("FAIL int_z: got %h want %h", rspz3[2*BWZ +: BWZ], fake_add(41'h3F, 41'h41));
        else n_pass++;
        drain;
    endtask

    task automatic test_reset_midop;
        do_reset;
        set_req(0, 41'hA0, 41'hA1, 3'b100);
        set_req(3, 41'hB0, 41'hB1, 3'b010);
        req_valid = 4'b1000;
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b1000) $display("FAIL midop_issue: got %b want 1000", rdy1);
        else n_pass++;
        tick;
        rst       = 1'b1;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (rspv1 !== 4'b0000 || rspv3 !== 4'b0000)
            $display("FAIL midop_in_reset: got %b/%b want 0000/0000", rspv1, rspv3);
        else n_pass++;
        tick;
        rst = 1'b0;
        clear_sb;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (rspv1 !== 4'b0000) $display("FAIL midop_discard T%0d: got %b want 0000", k, rspv1);
            else n_pass++;
            tick;
        end
        req_valid = 4'b1001;
        push(0);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0001) $display("FAIL midop_first_grant: got %b want 0001", rdy1);
        else n_pass++;
        tick;
        push(3);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b1000) $display("FAIL midop_inflight_cleared: got %b want 1000", rdy1);
        else n_pass++;
        tick;
        drain;
    endtask

`ifdef NE_FP_ADD_ARB_STATS_EN
    task automatic test_stats;
        do_reset;
        set_req(0, 41'h10, 41'h11, 3'b100);
        set_req(1, 41'h20, 41'h21, 3'b100);
        set_req(2, 41'h30, 41'h31, 3'b010);
        req_valid = 4'b0010;
        push(1);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0010) $display("FAIL stats_grant1: got %b want 0010", rdy1);
        else n_pass++;
        tick;
        req_valid = 4'b0101;
        push(2);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0100) $display("FAIL stats_grant2: got %b want 0100", rdy1);
        else n_pass++;
        tick;
        req_valid = 4'b0001;
        push(0);
        @(negedge clk);
        n_checks++;
        if (rdy1 !== 4'b0001) $display("FAIL stats_grant0: got %b want 0001", rdy1);
        else n_pass++;
        tick;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if (si1 !== {16'd0, 16'd1, 16'd1, 16'd1})
            $display("FAIL stats_issue: got %h want %h", si1, {16'd0, 16'd1, 16'd1, 16'd1});
        else n_pass++;
        n_checks++;
        if (ss1 !== {16'd0, 16'd0, 16'd0, 16'd1})
            $display("FAIL stats_stall: got %h want %h", ss1, {16'd0, 16'd0, 16'd0, 16'd1});
        else n_pass++;
        drain;
    endtask
`endif

    task automatic test_final;
        for (int i = 0; i < NREQ; i++) begin
            n_checks++;
            if (exp_q[i].size() != 0)
                $display("FAIL sb_leftover req%0d: got %0d pending want 0", i, exp_q[i].size());
            else n_pass++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '1;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        test_reset;
        test_single;
        test_contention;
        test_backpressure;
        test_int;
        test_final;
        test_reset_midop;
`ifdef NE_FP_ADD_ARB_STATS_EN
        test_stats;
`endif
        test_final;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
